// File: rtl/hazard_stall_unit_if.sv
// rtl/hazard_stall_unit_if.sv - pipeline <-> hazard stall unit signal bundle
//
// Purpose: groups the ID/EX hazard sources, mul/div scoreboard events,
// memory wait strobes and the resulting pipeline control outputs.
// Ports (modports):
//   master - pipeline side: drives hazard sources, receives controls
//   slave  - hazard_stall_unit side: receives sources, drives controls
interface hazard_stall_unit_if #(
  parameter int CNT_W = 32
);
  // ID stage
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [4:0]       id_rd;
  logic             id_RegWEn;
  logic             id_is_md;
  // EX stage
  logic [4:0]       ex_rd;
  logic             ex_MemRead;
  logic             ex_branch_taken;
  // mul/div unit
  logic             md_issue;
  logic [4:0]       md_issue_rd;
  logic             md_wb;
  logic [4:0]       md_wb_rd;
  // memory waits
  logic             im_wait;
  logic             dm_wait;
  // controls and status
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pipe_freeze;
  logic             md_busy;
  logic             timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_RegWEn, id_is_md,
    output ex_rd, ex_MemRead, ex_branch_taken,
    output md_issue, md_issue_rd, md_wb, md_wb_rd,
    output im_wait, dm_wait,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze,
    input  md_busy, timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_RegWEn, id_is_md,
    input  ex_rd, ex_MemRead, ex_branch_taken,
    input  md_issue, md_issue_rd, md_wb, md_wb_rd,
    input  im_wait, dm_wait,
    output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze,
    output md_busy, timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - stall/flush controller for the 5-stage RV32 core
//
// Purpose: resolves hazards forwarding cannot: load-use, pending mul/div
// results (scoreboard), taken-branch flush and memory-wait freeze. Also
// keeps stall/flush perf counters and a sticky memory-wait watchdog.
// Ports:
//   clk - clock
//   rst - asynchronous active-high reset
//   hz  - hazard_stall_unit_if.slave: hazard sources in, pipeline controls,
//         md_busy, timeout, stall_cnt, flush_cnt out
module hazard_stall_unit #(
  parameter int MD_REGS      = 32,
  parameter int WAIT_TIMEOUT = 1024,
  parameter int CNT_W        = 32
) (
  input  logic            clk,
  input  logic            rst,
  hazard_stall_unit_if.slave hz
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_FREEZE = 1'b1;

  localparam int              WD_W    = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WAIT_TIMEOUT - 1);

  logic [0:0]         state;
  logic [WD_W-1:0]    wd_cnt;
  logic [WD_W-1:0]    wd_inc;
  logic               timeout_q;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic [CNT_W-1:0]   flush_cnt_q;

  // x0 is never tracked, so the register starts at index 1
  logic [MD_REGS-1:1] pending;
  logic [MD_REGS-1:1] pend_set;
  logic [MD_REGS-1:1] pend_clr;
  logic [31:0]        pend32;

  logic freeze_req;
  logic load_use;
  logic raw_hz;
  logic waw_hz;
  logic struct_hz;
  logic data_hz;
  logic md_busy_w;

  logic pc_write_w;
  logic ifid_write_w;
  logic ifid_flush_w;
  logic idex_bubble_w;
  logic pipe_freeze_w;

  assign freeze_req = hz.im_wait | hz.dm_wait;
  assign md_busy_w  = |pending;

  // 32-entry view with bit 0 tied low so a 5-bit register index can look it up
  assign pend32 = 32'({pending, 1'b0});

  // ------------------------------------------------------------------
  // Hazard detection
  // ------------------------------------------------------------------
  always_comb begin
    load_use = 1'b0;
    raw_hz   = 1'b0;
    if (hz.ex_MemRead && (hz.ex_rd != 5'd0)) begin
      load_use = (hz.id_rs1_used && (hz.ex_rd == hz.id_rs1)) ||
                 (hz.id_rs2_used && (hz.ex_rd == hz.id_rs2));
    end
    // The writeback clear is registered, so a result returning this cycle
    // still stalls its consumer for this cycle.
    raw_hz    = (hz.id_rs1_used && (hz.id_rs1 != 5'd0) && pend32[hz.id_rs1]) ||
                (hz.id_rs2_used && (hz.id_rs2 != 5'd0) && pend32[hz.id_rs2]);
    waw_hz    = hz.id_RegWEn && pend32[hz.id_rd];
    struct_hz = hz.id_is_md && md_busy_w;
    data_hz   = load_use | raw_hz | waw_hz | struct_hz;
  end

  // ------------------------------------------------------------------
  // Pipeline controls, highest priority first
  // ------------------------------------------------------------------
  always_comb begin
    pc_write_w    = 1'b1;
    ifid_write_w  = 1'b1;
    ifid_flush_w  = 1'b0;
    idex_bubble_w = 1'b0;
    pipe_freeze_w = 1'b0;
    if (freeze_req) begin
      // A taken branch sits frozen in EX; its flush lands once the wait ends.
      pc_write_w    = 1'b0;
      ifid_write_w  = 1'b0;
      pipe_freeze_w = 1'b1;
    end else if (hz.ex_branch_taken) begin
      // ID is squashed, so any data hazard it carries is irrelevant.
      ifid_flush_w  = 1'b1;
      idex_bubble_w = 1'b1;
    end else if (data_hz) begin
      pc_write_w    = 1'b0;
      ifid_write_w  = 1'b0;
      idex_bubble_w = 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Scoreboard
  // ------------------------------------------------------------------
  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    for (int i = 1; i < MD_REGS; i++) begin
      pend_set[i] = hz.md_issue && (32'(hz.md_issue_rd) == i);
      pend_clr[i] = hz.md_wb    && (32'(hz.md_wb_rd)    == i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      // set wins over a same-cycle clear of the same register
      pending <= pend_set | (pending & ~pend_clr);
    end
  end

  // ------------------------------------------------------------------
  // Freeze FSM and watchdog
  // ------------------------------------------------------------------
  assign wd_inc = wd_cnt + WD_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          wd_cnt <= '0;
          if (freeze_req) begin
            state <= ST_FREEZE;
          end
        end
        ST_FREEZE: begin
          // saturate so a very long wait cannot wrap back to zero
          if (wd_cnt != WD_LAST) begin
            wd_cnt <= wd_inc;
            if (wd_inc == WD_LAST) begin
              timeout_q <= 1'b1;
            end
          end
          if (!freeze_req) begin
            state <= ST_RUN;
          end
        end
        default: begin
          state  <= ST_RUN;
          wd_cnt <= '0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Perf counters (wrap naturally)
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write_w) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (ifid_flush_w) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign hz.pc_write    = pc_write_w;
  assign hz.ifid_write  = ifid_write_w;
  assign hz.ifid_flush  = ifid_flush_w;
  assign hz.idex_bubble = idex_bubble_w;
  assign hz.pipe_freeze = pipe_freeze_w;
  assign hz.md_busy     = md_busy_w;
  assign hz.timeout     = timeout_q;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - self-checking bench for hazard_stall_unit
module tb_hazard_stall_unit;

  localparam int MD_REGS = 32;
  localparam int WT      = 16;
  localparam int CW      = 16;

  // control word order: {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze}
  localparam logic [4:0] C_PASS  = 5'b11000;
  localparam logic [4:0] C_STALL = 5'b00010;
  localparam logic [4:0] C_FLUSH = 5'b11110;
  localparam logic [4:0] C_FRZ   = 5'b00001;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hazard_stall_unit_if #(.CNT_W(CW)) hif ();

  hazard_stall_unit #(
    .MD_REGS(MD_REGS), .WAIT_TIMEOUT(WT), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       regwen, is_md;
    logic [4:0] ex_rd;
    logic       memread, br, imw, dmw;
    logic [4:0] ctl;
  } vec_t;

  typedef struct {
    string      name;
    logic [4:0] ctl;
    logic       busy;
    logic       to;
  } exp_t;

  exp_t    q[$];
  vec_t    tbl[11];
  int      nvec = 0;
  int      errs = 0;
  logic [CW-1:0] m_stall = '0;
  logic [CW-1:0] m_flush = '0;
  logic    exp_to = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic idle();
    hif.id_rs1 = 0; hif.id_rs2 = 0; hif.id_rs1_used = 0; hif.id_rs2_used = 0;
    hif.id_rd = 0; hif.id_RegWEn = 0; hif.id_is_md = 0;
    hif.ex_rd = 0; hif.ex_MemRead = 0; hif.ex_branch_taken = 0;
    hif.md_issue = 0; hif.md_issue_rd = 0; hif.md_wb = 0; hif.md_wb_rd = 0;
    hif.im_wait = 0; hif.dm_wait = 0;
  endtask

  function automatic logic [4:0] ctl_now();
    return {hif.pc_write, hif.ifid_write, hif.ifid_flush, hif.idex_bubble, hif.pipe_freeze};
  endfunction

  // Inputs are already driven (#1 after posedge). Push the expectation,
  // pop and compare at negedge, then advance the counter model.
  task automatic step(input string nm, input logic [4:0] ctl, input logic busy);
    exp_t e;
    exp_t g;
    e.name = nm; e.ctl = ctl; e.busy = busy; e.to = exp_to;
    q.push_back(e);
    @(negedge clk);
    if (q.size() == 0) begin
      cmp({nm, ".queue"}, 32'd0, 32'd1);
    end else begin
      g = q.pop_front();
      cmp({g.name, ".ctl"},     32'(ctl_now()),      32'(g.ctl));
      cmp({g.name, ".busy"},    32'(hif.md_busy),    32'(g.busy));
      cmp({g.name, ".timeout"}, 32'(hif.timeout),    32'(g.to));
      cmp({g.name, ".stall"},   32'(hif.stall_cnt),  32'(m_stall));
      cmp({g.name, ".flush"},   32'(hif.flush_cnt),  32'(m_flush));
      if (!g.ctl[4]) m_stall = m_stall + 1'b1;
      if (g.ctl[2])  m_flush = m_flush + 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    //            name        rs1 rs2 u1 u2 rd rw md exrd mr br im dm ctl
    tbl[0]  = '{"v_idle",     0,  0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, C_PASS};
    tbl[1]  = '{"v_lu_rs1",   3,  0,  1, 0, 0, 0, 0, 3,   1, 0, 0, 0, C_STALL};
    tbl[2]  = '{"v_lu_unused",0,  4,  0, 0, 0, 0, 0, 4,   1, 0, 0, 0, C_PASS};
    tbl[3]  = '{"v_lu_x0",    0,  0,  1, 1, 0, 0, 0, 0,   1, 0, 0, 0, C_PASS};
    tbl[4]  = '{"v_lu_miss",  5,  6,  1, 1, 0, 0, 0, 4,   1, 0, 0, 0, C_PASS};
    tbl[5]  = '{"v_branch",   0,  0,  0, 0, 0, 0, 0, 0,   0, 1, 0, 0, C_FLUSH};
    tbl[6]  = '{"v_br_lu",    2,  0,  1, 0, 0, 0, 0, 2,   1, 1, 0, 0, C_FLUSH};
    tbl[7]  = '{"v_imw",      0,  0,  0, 0, 0, 0, 0, 0,   0, 0, 1, 0, C_FRZ};
    tbl[8]  = '{"v_dmw_br",   0,  0,  0, 0, 0, 0, 0, 0,   0, 1, 0, 1, C_FRZ};
    tbl[9]  = '{"v_dmw_lu",   8,  0,  1, 0, 0, 0, 0, 8,   1, 0, 0, 1, C_FRZ};
    tbl[10] = '{"v_md_free",  0,  0,  0, 0, 9, 1, 1, 0,   0, 0, 0, 0, C_PASS};

    idle();
    #3;
    cmp("rst.ctl",   32'(ctl_now()),     32'(C_PASS));
    cmp("rst.busy",  32'(hif.md_busy),   32'd0);
    cmp("rst.to",    32'(hif.timeout),   32'd0);
    cmp("rst.stall", 32'(hif.stall_cnt), 32'd0);
    cmp("rst.flush", 32'(hif.flush_cnt), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // load then use
    idle(); hif.ex_MemRead = 1; hif.ex_rd = 5; hif.id_rs2 = 5; hif.id_rs2_used = 1;
    step("lu_stall", C_STALL, 0);
    idle(); hif.id_rs2 = 5; hif.id_rs2_used = 1;
    step("lu_release", C_PASS, 0);

    // stateless table
    for (int i = 0; i < 11; i++) begin
      idle();
      hif.id_rs1 = tbl[i].rs1; hif.id_rs2 = tbl[i].rs2;
      hif.id_rs1_used = tbl[i].u1; hif.id_rs2_used = tbl[i].u2;
      hif.id_rd = tbl[i].rd; hif.id_RegWEn = tbl[i].regwen; hif.id_is_md = tbl[i].is_md;
      hif.ex_rd = tbl[i].ex_rd; hif.ex_MemRead = tbl[i].memread;
      hif.ex_branch_taken = tbl[i].br; hif.im_wait = tbl[i].imw; hif.dm_wait = tbl[i].dmw;
      step(tbl[i].name, tbl[i].ctl, 0);
    end

    // mul/div RAW on x7
    idle(); hif.md_issue = 1; hif.md_issue_rd = 7;
    step("md_issue7", C_PASS, 0);
    for (int i = 0; i < 2; i++) begin
      idle(); hif.id_rs1 = 7; hif.id_rs1_used = 1;
      step("md_raw7", C_STALL, 1);
    end
    idle(); hif.id_rs1 = 7; hif.id_rs1_used = 1; hif.md_wb = 1; hif.md_wb_rd = 7;
    step("md_raw7_wb", C_STALL, 1);
    idle(); hif.id_rs1 = 7; hif.id_rs1_used = 1;
    step("md_raw7_done", C_PASS, 0);

    // WAW and structural on x9
    idle(); hif.md_issue = 1; hif.md_issue_rd = 9;
    step("md_issue9", C_PASS, 0);
    idle(); hif.id_rd = 9; hif.id_RegWEn = 1;
    step("md_waw9", C_STALL, 1);
    idle(); hif.id_rd = 3; hif.id_RegWEn = 1;
    step("md_waw_other", C_PASS, 1);
    idle(); hif.id_is_md = 1; hif.id_rd = 4;
    step("md_struct", C_STALL, 1);
    idle(); hif.id_is_md = 1; hif.id_rd = 4; hif.md_wb = 1; hif.md_wb_rd = 9;
    step("md_struct_wb", C_STALL, 1);
    idle(); hif.id_is_md = 1; hif.id_rd = 4;
    step("md_struct_done", C_PASS, 0);

    // same-cycle issue and writeback to x7: set wins
    idle(); hif.md_issue = 1; hif.md_issue_rd = 7;
    step("md_reissue7", C_PASS, 0);
    idle(); hif.md_issue = 1; hif.md_issue_rd = 7; hif.md_wb = 1; hif.md_wb_rd = 7;
    step("md_setclr7", C_PASS, 1);
    idle(); hif.id_rs2 = 7; hif.id_rs2_used = 1;
    step("md_setwins7", C_STALL, 1);
    idle(); hif.md_wb = 1; hif.md_wb_rd = 7;
    step("md_clr7", C_PASS, 1);
    idle();
    step("md_clear", C_PASS, 0);

    // x0 is never tracked
    idle(); hif.md_issue = 1; hif.md_issue_rd = 0;
    step("x0_issue", C_PASS, 0);
    idle(); hif.id_rs1 = 0; hif.id_rs1_used = 1; hif.id_RegWEn = 1; hif.id_is_md = 1;
    step("x0_nobusy", C_PASS, 0);

    // branch held under a 3-cycle data wait, flushed afterwards
    for (int i = 0; i < 3; i++) begin
      idle(); hif.dm_wait = 1; hif.ex_branch_taken = 1;
      step("br_frozen", C_FRZ, 0);
    end
    idle(); hif.ex_branch_taken = 1;
    step("br_flush", C_FLUSH, 0);
    idle();
    step("br_after", C_PASS, 0);

    // watchdog
    for (int i = 0; i < WT; i++) begin
      idle(); hif.im_wait = 1;
      step("wd_wait", C_FRZ, 0);
    end
    exp_to = 1'b1;
    idle();
    step("wd_set", C_PASS, 0);
    step("wd_sticky", C_PASS, 0);

    // reset asserted mid-freeze with a mul/div outstanding
    idle(); hif.im_wait = 1; hif.md_issue = 1; hif.md_issue_rd = 3;
    step("rf_freeze", C_FRZ, 0);
    idle(); hif.im_wait = 1;
    step("rf_busy", C_FRZ, 1);
    rst = 1'b1;
    idle();
    #1;
    cmp("rf.ctl",   32'(ctl_now()),     32'(C_PASS));
    cmp("rf.busy",  32'(hif.md_busy),   32'd0);
    cmp("rf.to",    32'(hif.timeout),   32'd0);
    cmp("rf.stall", 32'(hif.stall_cnt), 32'd0);
    cmp("rf.flush", 32'(hif.flush_cnt), 32'd0);
    m_stall = '0; m_flush = '0; exp_to = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    idle(); hif.id_rs1 = 3; hif.id_rs1_used = 1;
    step("rf_after", C_PASS, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall/flush controller for the 5-stage RV32 core, paired with the forwarding logic: it handles every hazard that forwarding cannot resolve.
- Hazards covered: load-use, pending results from the multi-cycle mul/div unit (scoreboard), taken-branch flush, and instruction/data memory wait freeze.
- Drives the PC and pipeline-register enables, bubble and flush controls, and holds perf/watchdog state.

Parameters:
- MD_REGS, 32, number of architectural registers tracked by the scoreboard (x0 never tracked).
- WAIT_TIMEOUT, 1024, consecutive frozen cycles before the sticky timeout flag sets.
- CNT_W, 32, width of the stall and flush perf counters.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- id_rs1  input  5  ID-stage source 1
- id_rs2  input  5  ID-stage source 2
- id_rs1_used  input  1  ID instruction reads rs1
- id_rs2_used  input  1  ID instruction reads rs2
- id_rd  input  5  ID-stage destination
- id_RegWEn  input  1  ID instruction writes rd
- id_is_md  input  1  ID instruction is mul/div
- ex_rd  input  5  EX-stage destination
- ex_MemRead  input  1  EX instruction is a load
- ex_branch_taken  input  1  EX resolved a taken branch or jump
- md_issue  input  1  mul/div accepted from EX this cycle
- md_issue_rd  input  5  destination of the issued mul/div
- md_wb  input  1  mul/div result written back this cycle
- md_wb_rd  input  5  destination of the written-back result
- im_wait  input  1  instruction memory not ready
- dm_wait  input  1  data memory not ready
- pc_write  output  1  PC update enable
- ifid_write  output  1  IF/ID register enable
- ifid_flush  output  1  clear IF/ID to NOP
- idex_bubble  output  1  insert NOP into ID/EX
- pipe_freeze  output  1  hold ID/EX, EX/MEM and MEM/WB
- md_busy  output  1  scoreboard has any pending entry
- timeout  output  1  sticky memory-wait watchdog flag
- stall_cnt  output  CNT_W  cycles with pc_write=0
- flush_cnt  output  CNT_W  taken-branch flushes applied

Behaviour:
- State: `pending[MD_REGS-1:1]` scoreboard; FSM {RUN, FREEZE}; watchdog counter `wd_cnt`; `timeout`; `stall_cnt`; `flush_cnt`.
- Reset (asynchronous, immediate): pending=0, FSM=RUN, wd_cnt=0, timeout=0, both counters=0.
- Reset output values: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, pipe_freeze=0, md_busy=0.
- Reset asserted mid-freeze or mid-mul/div discards all pending state.
- freeze_req = im_wait | dm_wait.
- FSM transitions: RUN->FREEZE when freeze_req; FREEZE->RUN in the first cycle freeze_req=0.
- wd_cnt: increments each FREEZE cycle and clears on RUN; when it reaches WAIT_TIMEOUT-1, timeout sets and stays set until reset.
- Outputs are combinational from current state plus inputs; zero-cycle latency. Priority is highest first:
  1. freeze_req=1: pc_write=0, ifid_write=0, pipe_freeze=1, ifid_flush=0, idex_bubble=0. A branch in EX is held frozen and its flush is applied once freeze drops.
  2. ex_branch_taken=1: ifid_flush=1 and idex_bubble=1, pc_write=1, ifid_write=1. Any simultaneous data hazard is ignored, because the ID instruction is being squashed.
  3. Data hazard: pc_write=0, ifid_write=0, idex_bubble=1. A data hazard is any of:
     - load-use: ex_MemRead, ex_rd!=0, and ex_rd equals a used rs.
     - RAW: pending[used rs]=1, with rs!=0.
     - WAW: id_RegWEn and pending[id_rd]=1.
     - structural: id_is_md and md_busy.
  4. Otherwise: pass-through defaults.
- Scoreboard update on clk, suppressed for index 0:
  - md_issue sets pending[md_issue_rd].
  - md_wb clears pending[md_wb_rd].
  - Same index set and cleared in one cycle: set wins.
  - md_busy = OR of pending.
- A mul/div writing back in the same cycle as the RAW check still stalls that cycle; the registered clear takes effect next cycle.
- stall_cnt increments every cycle pc_write=0. flush_cnt increments every cycle ifid_flush=1.
- Both counters wrap modulo 2^CNT_W.

Test Plan:
- Load then use: ex_MemRead=1, ex_rd=5, id_rs2=5, id_rs2_used=1 -> one cycle with pc_write=0 and idex_bubble=1. Next cycle ex_MemRead=0 -> pass-through; stall_cnt=1.
- Mul/div RAW: md_issue with rd=7, then ID reads x7 -> stall holds until the cycle after md_wb_rd=7. Same-cycle issue/wb to x7 -> x7 remains pending.
- Branch during dm_wait held 3 cycles: pipe_freeze=1 for 3 cycles with no flush. Fourth cycle -> ifid_flush=1, idex_bubble=1, flush_cnt=1.
- Branch plus load-use in the same cycle -> flush wins: pc_write=1, ifid_flush=1.
- x0 cases: ex_rd=0 load-use -> no stall. md_issue_rd=0 -> md_busy stays 0.
- Watchdog and reset: im_wait held WAIT_TIMEOUT cycles -> timeout=1 and stays set after im_wait drops. Asserting rst mid-freeze -> all outputs return to reset values immediately.
